// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: shares the single L2 request port between the L1 instruction
// cache controller (read-only refills) and the L1 data cache controller
// (refills and write-backs). One requester owns the port per transaction:
// IDLE -> REQ (strobe held until L2 completes) -> RESP (one-cycle pulse).
// Optional build macro ARB_FIXED_PRIO_EN: the D side always wins a contested
// IDLE cycle instead of the default round-robin.
module l1_l2_arbiter #(
  parameter int TNUM2     = 18,
  parameter int INUM2     = 8,
  parameter int BIT_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 read_I_arb,
  input  logic [TNUM2-1:0]     tag_I_arb,
  input  logic [INUM2-1:0]     index_I_arb,
  output logic                 ready_arb_I,
  output logic [BIT_WIDTH-1:0] read_data_arb_I,
  input  logic                 read_D_arb,
  input  logic                 write_D_arb,
  input  logic [TNUM2-1:0]     tag_D_arb,
  input  logic [INUM2-1:0]     index_D_arb,
  input  logic [BIT_WIDTH-1:0] write_data_D_arb,
  output logic                 ready_arb_D,
  output logic [BIT_WIDTH-1:0] read_data_arb_D,
  output logic                 read_arb_L2,
  output logic                 write_arb_L2,
  output logic [TNUM2-1:0]     tag_arb_L2,
  output logic [INUM2-1:0]     index_arb_L2,
  output logic [BIT_WIDTH-1:0] write_data_arb_L2,
  input  logic                 ready_L2_arb,
  input  logic [BIT_WIDTH-1:0] read_data_L2_arb,
  output logic [1:0]           grant_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  logic [1:0]           state;
  logic [1:0]           owner;
  logic                 op_write;
  logic [TNUM2-1:0]     tag_q;
  logic [INUM2-1:0]     index_q;
  logic [BIT_WIDTH-1:0] wdata_q;
  logic [BIT_WIDTH-1:0] rdata_q;
  logic                 req_i;
  logic                 req_d;
  logic                 pick_d;
  logic                 start;

  assign req_i = read_I_arb;
  assign req_d = read_D_arb | write_D_arb;
  assign start = (state == IDLE) && (req_i || req_d);

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: any D request beats a simultaneous I request
  always_comb begin
    pick_d = req_d;
  end
`else
  // 1 means the D side owned the most recent grant; reset treats D as last
  logic last_grant_d;

  // Round-robin: on a contested cycle the side that was not granted last wins
  always_comb begin
    pick_d = req_d & (~req_i | ~last_grant_d);
  end

  // Remember the most recent winner each time a transaction starts
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_grant_d <= 1'b1;
    end else if (start) begin
      last_grant_d <= pick_d;
    end
  end
`endif

  // Transaction sequencer: latch the winner's request, hold it toward L2,
  // capture the returned line and spend one cycle handing it back
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      owner    <= GRANT_NONE;
      op_write <= 1'b0;
      tag_q    <= '0;
      index_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= REQ;
            if (pick_d) begin
              owner    <= GRANT_D;
              op_write <= write_D_arb;
              tag_q    <= tag_D_arb;
              index_q  <= index_D_arb;
              wdata_q  <= write_D_arb ? write_data_D_arb : '0;
            end else begin
              owner    <= GRANT_I;
              op_write <= 1'b0;
              tag_q    <= tag_I_arb;
              index_q  <= index_I_arb;
              wdata_q  <= '0;
            end
          end
        end
        REQ: begin
          if (ready_L2_arb) begin
            state   <= RESP;
            rdata_q <= read_data_L2_arb;
          end
        end
        RESP: begin
          state <= IDLE;
          owner <= GRANT_NONE;
        end
        default: begin
          state <= IDLE;
          owner <= GRANT_NONE;
        end
      endcase
    end
  end

  assign grant_o           = owner;
  assign read_arb_L2       = (state == REQ) & ~op_write;
  assign write_arb_L2      = (state == REQ) & op_write;
  assign tag_arb_L2        = tag_q;
  assign index_arb_L2      = index_q;
  assign write_data_arb_L2 = wdata_q;

  assign ready_arb_I     = (state == RESP) & (owner == GRANT_I);
  assign ready_arb_D     = (state == RESP) & (owner == GRANT_D);
  assign read_data_arb_I = ready_arb_I ? rdata_q : '0;
  assign read_data_arb_D = ready_arb_D ? rdata_q : '0;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter: self-checking bench for l1_l2_arbiter. A table of
// transactions with hand-derived grants, directed corner sequences and a
// randomized run, all compared against a transaction-level model that tracks
// pending requests per side and who was granted last.
// Honours ARB_FIXED_PRIO_EN the same way the design does.
module tb_l1_l2_arbiter;

  localparam int TW = 18;
  localparam int IW = 8;
  localparam int DW = 512;

  logic          clk;
  logic          nrst;
  logic          read_I_arb;
  logic [TW-1:0] tag_I_arb;
  logic [IW-1:0] index_I_arb;
  logic          ready_arb_I;
  logic [DW-1:0] read_data_arb_I;
  logic          read_D_arb;
  logic          write_D_arb;
  logic [TW-1:0] tag_D_arb;
  logic [IW-1:0] index_D_arb;
  logic [DW-1:0] write_data_D_arb;
  logic          ready_arb_D;
  logic [DW-1:0] read_data_arb_D;
  logic          read_arb_L2;
  logic          write_arb_L2;
  logic [TW-1:0] tag_arb_L2;
  logic [IW-1:0] index_arb_L2;
  logic [DW-1:0] write_data_arb_L2;
  logic          ready_L2_arb;
  logic [DW-1:0] read_data_L2_arb;
  logic [1:0]    grant_o;

  l1_l2_arbiter #(.TNUM2(TW), .INUM2(IW), .BIT_WIDTH(DW)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .read_I_arb       (read_I_arb),
    .tag_I_arb        (tag_I_arb),
    .index_I_arb      (index_I_arb),
    .ready_arb_I      (ready_arb_I),
    .read_data_arb_I  (read_data_arb_I),
    .read_D_arb       (read_D_arb),
    .write_D_arb      (write_D_arb),
    .tag_D_arb        (tag_D_arb),
    .index_D_arb      (index_D_arb),
    .write_data_D_arb (write_data_D_arb),
    .ready_arb_D      (ready_arb_D),
    .read_data_arb_D  (read_data_arb_D),
    .read_arb_L2      (read_arb_L2),
    .write_arb_L2     (write_arb_L2),
    .tag_arb_L2       (tag_arb_L2),
    .index_arb_L2     (index_arb_L2),
    .write_data_arb_L2(write_data_arb_L2),
    .ready_L2_arb     (ready_L2_arb),
    .read_data_L2_arb (read_data_L2_arb),
    .grant_o          (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model: requests pending on each side and their payloads
  logic          pendI, pendDr, pendDw;
  logic [TW-1:0] tagI, tagD;
  logic [IW-1:0] idxI, idxD;
  logic [DW-1:0] wdD;
  logic          lastWasI;

  typedef struct {
    logic       newI;
    logic       newDr;
    logic       newDw;
    int         delay;
    logic [1:0] expGrant;
    logic       expRd;
    logic       expWr;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive the request pins from the model's pending state
  task automatic applyStimulus();
    read_I_arb       = pendI;
    tag_I_arb        = tagI;
    index_I_arb      = idxI;
    read_D_arb       = pendDr;
    write_D_arb      = pendDw;
    tag_D_arb        = tagD;
    index_D_arb      = idxD;
    write_data_D_arb = wdD;
  endtask

  task automatic resetModel();
    pendI    = 1'b0;
    pendDr   = 1'b0;
    pendDw   = 1'b0;
    lastWasI = 1'b0;
  endtask

  task automatic checkAllZero(input string tagName);
    checkOutput({tagName, "_grant"}, grant_o, '0);
    checkOutput({tagName, "_strobes"}, {read_arb_L2, write_arb_L2}, '0);
    checkOutput({tagName, "_readys"}, {ready_arb_I, ready_arb_D}, '0);
    checkOutput({tagName, "_tag"}, tag_arb_L2, '0);
    checkOutput({tagName, "_index"}, index_arb_L2, '0);
    checkOutput({tagName, "_wdata"}, write_data_arb_L2, '0);
    checkOutput({tagName, "_rdata_i"}, read_data_arb_I, '0);
    checkOutput({tagName, "_rdata_d"}, read_data_arb_D, '0);
  endtask

  // One idle cycle with no requests; a spurious L2 ready must not start anything
  task automatic idleCycle(input logic spurious);
    applyStimulus();
    ready_L2_arb     = spurious;
    read_data_L2_arb = rand512();
    @(negedge clk);
    checkOutput("idle_only_grant", grant_o, '0);
    checkOutput("idle_only_strobes", {read_arb_L2, write_arb_L2}, '0);
    checkOutput("idle_only_readys", {ready_arb_I, ready_arb_D}, '0);
    @(posedge clk); #1;
    ready_L2_arb = 1'b0;
  endtask

  // Run one whole transaction from an IDLE cycle with requests pending.
  // The model decides the winner; L2 answers in the delay-th REQ cycle.
  task automatic doTxn(input int delay, input logic [DW-1:0] l2data,
                       output logic [1:0] obsGrant, output logic obsRd, output logic obsWr);
    logic          winD, isWr;
    logic [1:0]    eg;
    logic [TW-1:0] et;
    logic [IW-1:0] ei;
    logic [DW-1:0] ew;
`ifdef ARB_FIXED_PRIO_EN
    winD = pendDr | pendDw;
`else
    winD = (pendDr | pendDw) && (!pendI || lastWasI);
`endif
    isWr = winD && pendDw;
    eg   = winD ? 2'b10 : 2'b01;
    et   = winD ? tagD : tagI;
    ei   = winD ? idxD : idxI;
    ew   = isWr ? wdD : '0;
    obsGrant = 2'b00;
    obsRd    = 1'b0;
    obsWr    = 1'b0;

    // IDLE: requests sampled; any L2 ready here is dropped
    applyStimulus();
    ready_L2_arb     = 1'($urandom_range(0, 1));
    read_data_L2_arb = rand512();
    @(negedge clk);
    checkOutput("idle_grant", grant_o, '0);
    checkOutput("idle_strobes", {read_arb_L2, write_arb_L2}, '0);
    checkOutput("idle_readys", {ready_arb_I, ready_arb_D}, '0);
    @(posedge clk); #1;

    // REQ: payload inputs are scrambled to show the registered copy is used
    for (int c = 0; c <= delay; c++) begin
      ready_L2_arb     = (c == delay);
      read_data_L2_arb = (c == delay) ? l2data : rand512();
      tag_I_arb        = TW'($urandom);
      index_I_arb      = IW'($urandom);
      tag_D_arb        = TW'($urandom);
      index_D_arb      = IW'($urandom);
      write_data_D_arb = rand512();
      @(negedge clk);
      if (c == 0) begin
        obsGrant = grant_o;
        obsRd    = read_arb_L2;
        obsWr    = write_arb_L2;
      end
      checkOutput("req_grant", grant_o, eg);
      checkOutput("req_read", read_arb_L2, !isWr);
      checkOutput("req_write", write_arb_L2, isWr);
      checkOutput("req_tag", tag_arb_L2, et);
      checkOutput("req_index", index_arb_L2, ei);
      checkOutput("req_wdata", write_data_arb_L2, ew);
      checkOutput("req_readys", {ready_arb_I, ready_arb_D}, '0);
      @(posedge clk); #1;
    end

    // RESP: one pulse to the owner, winner drops its request before the edge
    ready_L2_arb     = 1'($urandom_range(0, 1));
    read_data_L2_arb = rand512();
    @(negedge clk);
    checkOutput("resp_ready_i", ready_arb_I, !winD);
    checkOutput("resp_ready_d", ready_arb_D, winD);
    checkOutput("resp_data_i", read_data_arb_I, winD ? '0 : l2data);
    checkOutput("resp_data_d", read_data_arb_D, winD ? l2data : '0);
    checkOutput("resp_strobes", {read_arb_L2, write_arb_L2}, '0);
    checkOutput("resp_grant", grant_o, eg);
    if (winD) begin
      if (isWr) pendDw = 1'b0;
      else      pendDr = 1'b0;
    end else begin
      pendI = 1'b0;
    end
    lastWasI = !winD;
    applyStimulus();
    @(posedge clk); #1;
    ready_L2_arb = 1'b0;
  endtask

  task automatic raiseI();
    pendI = 1'b1;
    tagI  = TW'($urandom);
    idxI  = IW'($urandom);
  endtask

  task automatic raiseD(input logic rd, input logic wr);
    pendDr = rd;
    pendDw = wr;
    tagD   = TW'($urandom);
    idxD   = IW'($urandom);
    wdD    = rand512();
  endtask

  task automatic raiseRandom();
    if (!pendI && $urandom_range(0, 1) == 1) raiseI();
    if (!pendDr && !pendDw && $urandom_range(0, 1) == 1) begin
      int op;
      op = int'($urandom_range(0, 2));
      raiseD(op != 1, op != 0);
    end
    if (!pendI && !pendDr && !pendDw) raiseI();
  endtask

  task automatic pulseReset();
    nrst = 1'b0;
    #1;
    checkAllZero("reset");
    @(negedge clk);
    nrst = 1'b1;
    resetModel();
    applyStimulus();
    @(posedge clk); #1;
  endtask

  logic [1:0] g;
  logic       rd, wr;

  initial begin
    nrst             = 1'b0;
    ready_L2_arb     = 1'b0;
    read_data_L2_arb = '0;
    tagI = '0; idxI = '0; tagD = '0; idxD = '0; wdD = '0;
    resetModel();
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("por");
    nrst = 1'b1;
    @(posedge clk); #1;

    // Round-robin / fixed-priority sequence starting from reset
`ifdef ARB_FIXED_PRIO_EN
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2, 2'b01, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1, 2'b10, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 0, 2'b10, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 3, 2'b01, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1, 2'b10, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 0, 2'b10, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2, 2'b01, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 0, 2'b10, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1, 2'b01, 1'b1, 1'b0};
`else
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2, 2'b01, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1, 2'b10, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 0, 2'b01, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 3, 2'b10, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1, 2'b01, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 0, 2'b10, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2, 2'b10, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 0, 2'b01, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1, 2'b10, 1'b0, 1'b1};
`endif
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].newI) raiseI();
      if (vecs[v].newDr || vecs[v].newDw) raiseD(vecs[v].newDr, vecs[v].newDw);
      doTxn(vecs[v].delay, rand512(), g, rd, wr);
      checkOutput($sformatf("vec%0d_grant", v), g, vecs[v].expGrant);
      checkOutput($sformatf("vec%0d_read", v), rd, vecs[v].expRd);
      checkOutput($sformatf("vec%0d_write", v), wr, vecs[v].expWr);
    end

    // I-side read with a known tag/index and an all-A5 refill line
    pendI = 1'b1; tagI = 18'h3A5C1; idxI = 8'h12;
    doTxn(4, {64{8'hA5}}, g, rd, wr);
    checkOutput("iread_grant", g, 2'b01);
    checkOutput("iread_write", wr, 1'b0);

    // D-side write-back
    pendDw = 1'b1; tagD = 18'h0F00D; idxD = 8'h80; wdD = {8{64'h0123456789ABCDEF}};
    doTxn(3, rand512(), g, rd, wr);
    checkOutput("dwb_write", wr, 1'b1);
    checkOutput("dwb_read", rd, 1'b0);

    // L2 answers in the very first REQ cycle, then spurious readys in IDLE
    raiseI();
    doTxn(0, rand512(), g, rd, wr);
    idleCycle(1'b1);
    idleCycle(1'b1);

    // Both sides request out of reset; the winner immediately re-raises
    pulseReset();
    raiseI();
    raiseD(1'b1, 1'b0);
    doTxn(2, rand512(), g, rd, wr);
`ifdef ARB_FIXED_PRIO_EN
    checkOutput("sim_first_grant", g, 2'b10);
    raiseD(1'b1, 1'b0);
`else
    checkOutput("sim_first_grant", g, 2'b01);
    raiseI();
`endif
    doTxn(1, rand512(), g, rd, wr);
    checkOutput("sim_second_grant", g, 2'b10);
    doTxn(0, rand512(), g, rd, wr);
    checkOutput("sim_third_grant", g, 2'b01);

    // Asynchronous reset while a D write-back sits in REQ
    raiseD(1'b0, 1'b1);
    wdD[0] = 1'b1;
    applyStimulus();
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midrst_pre_write", write_arb_L2, 1'b1);
    #2;
    nrst = 1'b0;
    #1;
    checkAllZero("midrst");
    resetModel();
    applyStimulus();
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    raiseI();
    raiseD(1'b1, 1'b0);
    doTxn(1, rand512(), g, rd, wr);
`ifdef ARB_FIXED_PRIO_EN
    checkOutput("midrst_first_grant", g, 2'b10);
`else
    checkOutput("midrst_first_grant", g, 2'b01);
`endif
    doTxn(0, rand512(), g, rd, wr);

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      raiseRandom();
      doTxn(int'($urandom_range(0, 5)), rand512(), g, rd, wr);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
